// File: rtl/hangy_host_if.sv
// hangy_host_if -- guess/result stream between a game client and hangy_host.
//   guess_valid/guess_char/guess_ready : valid/ready stream of 5-bit guesses
//   res_valid                          : one-cycle result strobe
//   res_code/res_mask/misses           : result of the last guess (held)
// The master modport is the client side; the slave modport is hangy_host.
interface hangy_host_if;
   logic       guess_valid;
   logic [4:0] guess_char;
   logic       guess_ready;
   logic       res_valid;
   logic [2:0] res_code;
   logic [4:0] res_mask;
   logic [3:0] misses;

   modport master (
      output guess_valid, guess_char,
      input  guess_ready, res_valid, res_code, res_mask, misses
   );

   modport slave (
      input  guess_valid, guess_char,
      output guess_ready, res_valid, res_code, res_mask, misses
   );
endinterface

// File: rtl/hangy_host.sv
// hangy_host -- host-side driver for the hangy game core.
// It turns accepted guesses into single-cycle {next, char} pulses on
// game_in and waits a fixed settle window. It then samples the core's
// {lose, win, mask} on game_out and reports one result per guess.
// Repeated guesses are answered locally as DUP, so the core never sees
// them. An unchanged mask therefore always means a real miss.
// Ports:
//   clk, reset : clock and synchronous active-high reset (shared with core)
//   start      : new game request, honoured only in IDLE or OVER
//   host       : guess stream in, result/miss count out (slave modport)
//   game_in    : [5]=next pulse, [4:0]=char, to the core's inputs
//   game_out   : [6]=lose, [5]=win, [4:0]=guessed mask, from the core
//   busy       : high while a pulse/settle/evaluate sequence is running
//   desync     : sticky flag, core answered inconsistently
// All outputs are registered.
module hangy_host #(
   parameter int SETTLE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   hangy_host_if.slave host,
   output logic [5:0]  game_in,
   input  logic [6:0]  game_out,
   output logic        busy,
   output logic        desync
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

   localparam logic [2:0] RC_MISS = 3'd0;
   localparam logic [2:0] RC_HIT  = 3'd1;
   localparam logic [2:0] RC_WIN  = 3'd2;
   localparam logic [2:0] RC_LOSE = 3'd3;
   localparam logic [2:0] RC_DUP  = 3'd4;

   typedef enum logic [3:0] {
      IDLE, START_PULSE, SETTLE, READY, SUBMIT, WAIT,
      EVAL, REJECT, OVER, EXIT_PULSE, SETTLE2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   used_q, used_d;
   logic [4:0]    prev_mask_q, prev_mask_d;
   logic [3:0]    misses_q, misses_d;
   logic          res_valid_q, res_valid_d;
   logic [2:0]    res_code_q, res_code_d;
   logic [4:0]    res_mask_q, res_mask_d;
   logic          next_q, next_d;
   logic [4:0]    char_q, char_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          desync_q, desync_d;

   logic          lose_s, win_s;
   logic [4:0]    mask_s, gained, lost;
   logic [3:0]    misses_inc;

   assign lose_s     = game_out[6];
   assign win_s      = game_out[5];
   assign mask_s     = game_out[4:0];
   // The core only ever adds letters. Gaining one bit while losing
   // another means it is no longer in step with us.
   assign gained     = mask_s & ~prev_mask_q;
   assign lost       = prev_mask_q & ~mask_s;
   assign misses_inc = (misses_q == 4'hF) ? misses_q : misses_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      used_d      = used_q;
      prev_mask_d = prev_mask_q;
      misses_d    = misses_q;
      res_valid_d = 1'b0;
      res_code_d  = res_code_q;
      res_mask_d  = res_mask_q;
      char_d      = char_q;
      desync_d    = desync_q;

      case (state_q)
         IDLE:        if (start) state_d = START_PULSE;
         START_PULSE: begin
            state_d = SETTLE;
            cnt_d   = CNT_LOAD;
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = READY;
            else             cnt_d   = cnt_q - CW'(1);
         end
         READY: begin
            if (host.guess_valid) begin
               if (used_q[host.guess_char]) begin
                  state_d = REJECT;
               end else begin
                  state_d                  = SUBMIT;
                  used_d[host.guess_char]  = 1'b1;
                  char_d                   = host.guess_char;
               end
            end
         end
         SUBMIT: begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = EVAL;
            else             cnt_d   = cnt_q - CW'(1);
         end
         EVAL: begin
            res_valid_d = 1'b1;
            res_mask_d  = mask_s;
            prev_mask_d = mask_s;
            if (lose_s) begin
               res_code_d = RC_LOSE;
               misses_d   = misses_inc;
            end else if (win_s) begin
               res_code_d = RC_WIN;
            end else if (mask_s != prev_mask_q) begin
               res_code_d = RC_HIT;
            end else begin
               res_code_d = RC_MISS;
               misses_d   = misses_inc;
            end
            if (((gained != '0) && (lost != '0)) || (win_s && lose_s) ||
                (win_s && (mask_s != 5'b11111)))
               desync_d = 1'b1;
            state_d = (lose_s || win_s) ? OVER : READY;
         end
         REJECT: begin
            res_valid_d = 1'b1;
            res_code_d  = RC_DUP;
            res_mask_d  = prev_mask_q;
            state_d     = READY;
         end
         OVER:        if (start) state_d = EXIT_PULSE;
         EXIT_PULSE: begin
            state_d = SETTLE2;
            cnt_d   = CNT_LOAD;
         end
         SETTLE2: begin
            if (cnt_q == '0) state_d = START_PULSE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default:     state_d = IDLE;
      endcase

      // Game-level state is wiped as the start pulse goes out. That way
      // misses already reads 0 while the core begins its new game.
      if (state_d == START_PULSE) begin
         used_d      = '0;
         prev_mask_d = '0;
         misses_d    = '0;
         char_d      = '0;
      end
      if (state_d == EXIT_PULSE) char_d = '0;

      // Outputs come from the next state so that they line up with it
      // once registered.
      next_d  = (state_d == START_PULSE) || (state_d == EXIT_PULSE) ||
                (state_d == SUBMIT);
      ready_d = (state_d == READY);
      busy_d  = !((state_d == IDLE) || (state_d == READY) || (state_d == OVER));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         used_q      <= '0;
         prev_mask_q <= '0;
         misses_q    <= '0;
         res_valid_q <= 1'b0;
         res_code_q  <= '0;
         res_mask_q  <= '0;
         next_q      <= 1'b0;
         char_q      <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         desync_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         used_q      <= used_d;
         prev_mask_q <= prev_mask_d;
         misses_q    <= misses_d;
         res_valid_q <= res_valid_d;
         res_code_q  <= res_code_d;
         res_mask_q  <= res_mask_d;
         next_q      <= next_d;
         char_q      <= char_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         desync_q    <= desync_d;
      end
   end

   assign host.guess_ready = ready_q;
   assign host.res_valid   = res_valid_q;
   assign host.res_code    = res_code_q;
   assign host.res_mask    = res_mask_q;
   assign host.misses      = misses_q;
   assign game_in          = {next_q, char_q};
   assign busy             = busy_q;
   assign desync           = desync_q;
endmodule

// File: tb/tb_hangy_host.sv
// tb_hangy_host -- directed bench for hangy_host with a small core model.
// The model's word has letters 3,7,11,19,25, which set mask bits
// 4,3,2,1,0 respectively. A next pulse with char 0 (start/exit) clears the
// model mask. Win is mask==11111. lose_m and ovr_en/ovr_mask let tests
// force core answers.
module tb_hangy_host;
   localparam int S = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] game_in;
   logic [6:0] game_out;
   logic       busy;
   logic       desync;

   logic [4:0] mask_m;
   logic       lose_m;
   logic       ovr_en;
   logic [4:0] ovr_mask;

   int errors = 0;
   int checks = 0;

   hangy_host_if hif();

   hangy_host #(.SETTLE_CYCLES(S)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .host     (hif),
      .game_in  (game_in),
      .game_out (game_out),
      .busy     (busy),
      .desync   (desync)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] hit_bits(input logic [4:0] c);
      case (c)
         5'd3:    return 5'b10000;
         5'd7:    return 5'b01000;
         5'd11:   return 5'b00100;
         5'd19:   return 5'b00010;
         5'd25:   return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset)
         mask_m <= 5'b0;
      else if (game_in[5] === 1'b1) begin
         if (game_in[4:0] == 5'd0) mask_m <= 5'b0;
         else                      mask_m <= mask_m | hit_bits(game_in[4:0]);
      end
   end

   assign game_out = ovr_en ? {2'b00, ovr_mask} : {lose_m, (mask_m == 5'h1f), mask_m};

   // Issues start during cycle T and observes cycles T+1..T+span.
   task automatic do_start(input int span, output int p1, output int p2,
                           output int np, output int rdy_at);
      p1 = -1; p2 = -1; np = 0; rdy_at = -1;
      start = 1'b1;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (game_in[5] === 1'b1) begin
            np++;
            if (p1 < 0) p1 = k; else p2 = k;
         end
         if (hif.guess_ready === 1'b1 && rdy_at < 0) rdy_at = k;
      end
   endtask

   // Offers one guess and follows it to its result strobe. lat is the
   // number of cycles from acceptance to res_valid, or -1 on timeout.
   task automatic guess(input logic [4:0] c, input int start_at, output int lat,
                        output logic [2:0] code, output logic [4:0] mask,
                        output logic [3:0] mis, output int npulse,
                        output logic held, output logic rdy);
      int w;
      lat = -1; code = '0; mask = '0; mis = '0; npulse = 0; held = 1'b1; rdy = 1'b0;
      w = 0;
      while (hif.guess_ready !== 1'b1 && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (hif.guess_ready !== 1'b1) return;
      hif.guess_valid = 1'b1;
      hif.guess_char  = c;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) hif.guess_valid = 1'b0;
         if (game_in[5] === 1'b1) npulse++;
         start = (k == start_at);
         if (hif.res_valid === 1'b1) begin
            lat  = k;
            code = hif.res_code;
            mask = hif.res_mask;
            mis  = hif.misses;
            rdy  = hif.guess_ready;
            break;
         end
         if (game_in[4:0] !== c) held = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({hif.guess_ready, hif.res_valid, hif.res_code, hif.res_mask, hif.misses,
           game_in, busy, desync} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b code=%0d mask=%b mis=%0d gi=%b busy=%b ds=%b want all 0",
                  hif.guess_ready, hif.res_valid, hif.res_code, hif.res_mask, hif.misses,
                  game_in, busy, desync);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({hif.guess_ready, game_in, busy} !== 8'd0) begin
         errors++;
         $display("FAIL idle_quiet: got rdy=%b gi=%b busy=%b want 0 0 0", hif.guess_ready, game_in, busy);
      end
   endtask

   task automatic test_start;
      int p1, p2, np, ra;
      do_start(S + 3, p1, p2, np, ra);
      checks++;
      if (p1 !== 1 || np !== 1) begin
         errors++;
         $display("FAIL start_pulse: got first=%0d count=%0d want first=1 count=1", p1, np);
      end
      checks++;
      if (ra !== S + 2) begin
         errors++;
         $display("FAIL start_ready: got %0d want %0d", ra, S + 2);
      end
      checks++;
      if (hif.misses !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_state: got misses=%0d busy=%b want 0 0", hif.misses, busy);
      end
   endtask

   task automatic test_hit;
      int lat, np; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      guess(5'd3, 0, lat, code, mask, mis, np, held, rdy);
      checks++;
      if (lat !== S + 3) begin
         errors++; $display("FAIL hit_latency: got %0d want %0d", lat, S + 3);
      end
      checks++;
      if ({code, mask, mis} !== {3'd1, 5'b10000, 4'd0}) begin
         errors++;
         $display("FAIL hit_result: got code=%0d mask=%b misses=%0d want 1 10000 0", code, mask, mis);
      end
      checks++;
      if (held !== 1'b1 || np !== 1 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL hit_bus: got held=%b pulses=%0d ready=%b want 1 1 1", held, np, rdy);
      end
      @(negedge clk);
      checks++;
      if (hif.res_valid !== 1'b0 || hif.res_code !== 3'd1) begin
         errors++;
         $display("FAIL hit_hold: got rv=%b code=%0d want 0 1", hif.res_valid, hif.res_code);
      end
   endtask

   task automatic test_dup;
      int lat, np; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      guess(5'd3, 0, lat, code, mask, mis, np, held, rdy);
      checks++;
      if (lat !== 2 || np !== 0) begin
         errors++; $display("FAIL dup_timing: got lat=%0d pulses=%0d want 2 0", lat, np);
      end
      checks++;
      if ({code, mask, mis, rdy} !== {3'd4, 5'b10000, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL dup_result: got code=%0d mask=%b misses=%0d ready=%b want 4 10000 0 1",
                  code, mask, mis, rdy);
      end
   endtask

   task automatic test_miss_saturate;
      logic [4:0] wrong [16] = '{5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10,
                                 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd20};
      int lat, np, em; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      for (int i = 0; i < 16; i++) begin
         guess(wrong[i], 0, lat, code, mask, mis, np, held, rdy);
         em = (i + 1 > 15) ? 15 : i + 1;
         checks++;
         if (lat !== S + 3 || {code, mask, mis} !== {3'd0, 5'b10000, 4'(em)}) begin
            errors++;
            $display("FAIL miss_%0d: got lat=%0d code=%0d mask=%b misses=%0d want lat=%0d code=0 mask=10000 misses=%0d",
                     i, lat, code, mask, mis, S + 3, em);
         end
      end
   endtask

   task automatic test_win;
      logic [4:0] chars [3] = '{5'd7, 5'd11, 5'd19};
      logic [4:0] masks [3] = '{5'b11000, 5'b11100, 5'b11110};
      int lat, np; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      for (int i = 0; i < 3; i++) begin
         guess(chars[i], 0, lat, code, mask, mis, np, held, rdy);
         checks++;
         if ({code, mask, mis} !== {3'd1, masks[i], 4'd15}) begin
            errors++;
            $display("FAIL win_hit_%0d: got code=%0d mask=%b misses=%0d want 1 %b 15",
                     i, code, mask, mis, masks[i]);
         end
      end
      guess(5'd25, 0, lat, code, mask, mis, np, held, rdy);
      checks++;
      if (lat !== S + 3 || {code, mask, mis, rdy} !== {3'd2, 5'b11111, 4'd15, 1'b0}) begin
         errors++;
         $display("FAIL win_result: got lat=%0d code=%0d mask=%b misses=%0d ready=%b want %0d 2 11111 15 0",
                  lat, code, mask, mis, rdy, S + 3);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({hif.guess_ready, busy, desync} !== 3'b000) begin
         errors++;
         $display("FAIL over_state: got ready=%b busy=%b desync=%b want 0 0 0", hif.guess_ready, busy, desync);
      end
   endtask

   task automatic test_restart;
      int p1, p2, np, ra, lat, npg; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      do_start(2 * S + 4, p1, p2, np, ra);
      checks++;
      if (np !== 2 || p1 !== 1 || p2 !== S + 2) begin
         errors++;
         $display("FAIL restart_pulses: got count=%0d at %0d,%0d want 2 at 1,%0d", np, p1, p2, S + 2);
      end
      checks++;
      if (ra !== 2 * S + 3 || hif.misses !== 4'd0) begin
         errors++;
         $display("FAIL restart_ready: got ready_at=%0d misses=%0d want %0d 0", ra, hif.misses, 2 * S + 3);
      end
      guess(5'd25, 0, lat, code, mask, mis, npg, held, rdy);
      checks++;
      if (lat !== S + 3 || {code, mask, mis} !== {3'd1, 5'b00001, 4'd0}) begin
         errors++;
         $display("FAIL restart_bitmap: got lat=%0d code=%0d mask=%b misses=%0d want %0d 1 00001 0",
                  lat, code, mask, mis, S + 3);
      end
   endtask

   task automatic test_desync_lose;
      int p1, p2, np, ra, lat; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_start(S + 3, p1, p2, np, ra);
      guess(5'd3, 0, lat, code, mask, mis, np, held, rdy);
      checks++;
      if ({code, mask, desync} !== {3'd1, 5'b10000, 1'b0}) begin
         errors++;
         $display("FAIL ds_setup: got code=%0d mask=%b desync=%b want 1 10000 0", code, mask, desync);
      end
      ovr_en = 1'b1; ovr_mask = 5'b01000;
      guess(5'd4, 4, lat, code, mask, mis, np, held, rdy);
      ovr_en = 1'b0;
      checks++;
      if (lat !== S + 3 || np !== 1) begin
         errors++;
         $display("FAIL ds_start_ignored: got lat=%0d pulses=%0d want %0d 1", lat, np, S + 3);
      end
      checks++;
      if ({code, mask, rdy, desync} !== {3'd1, 5'b01000, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL ds_flag: got code=%0d mask=%b ready=%b desync=%b want 1 01000 1 1",
                  code, mask, rdy, desync);
      end
      guess(5'd5, 0, lat, code, mask, mis, np, held, rdy);
      lose_m = 1'b1;
      guess(5'd6, 0, lat, code, mask, mis, np, held, rdy);
      lose_m = 1'b0;
      checks++;
      if (lat !== S + 3 || {code, mask, mis, rdy} !== {3'd3, 5'b10000, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL lose_result: got lat=%0d code=%0d mask=%b misses=%0d ready=%b want %0d 3 10000 1 0",
                  lat, code, mask, mis, rdy, S + 3);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (desync !== 1'b1 || hif.guess_ready !== 1'b0) begin
         errors++;
         $display("FAIL ds_sticky: got desync=%b ready=%b want 1 0", desync, hif.guess_ready);
      end
   endtask

   task automatic test_reset_mid_wait;
      int p1, p2, np, ra, lat; logic [2:0] code; logic [4:0] mask; logic [3:0] mis; logic held, rdy;
      do_start(2 * S + 4, p1, p2, np, ra);
      checks++;
      if (ra !== 2 * S + 3) begin
         errors++; $display("FAIL rmw_ready: got %0d want %0d", ra, 2 * S + 3);
      end
      hif.guess_valid = 1'b1;
      hif.guess_char  = 5'd9;
      @(negedge clk);
      hif.guess_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({hif.guess_ready, hif.res_valid, hif.res_code, hif.res_mask, hif.misses,
           game_in, busy, desync} !== 22'd0) begin
         errors++;
         $display("FAIL rmw_outputs: got rdy=%b rv=%b code=%0d mask=%b mis=%0d gi=%b busy=%b ds=%b want all 0",
                  hif.guess_ready, hif.res_valid, hif.res_code, hif.res_mask, hif.misses,
                  game_in, busy, desync);
      end
      reset = 1'b0;
      @(negedge clk);
      do_start(S + 3, p1, p2, np, ra);
      checks++;
      if (np !== 1 || p1 !== 1 || ra !== S + 2) begin
         errors++;
         $display("FAIL rmw_idle_start: got pulses=%0d first=%0d ready_at=%0d want 1 1 %0d", np, p1, ra, S + 2);
      end
      guess(5'd9, 0, lat, code, mask, mis, np, held, rdy);
      checks++;
      if (lat !== S + 3 || {code, mask, mis} !== {3'd0, 5'b00000, 4'd1}) begin
         errors++;
         $display("FAIL rmw_guess: got lat=%0d code=%0d mask=%b misses=%0d want %0d 0 00000 1",
                  lat, code, mask, mis, S + 3);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      lose_m = 1'b0;
      ovr_en = 1'b0;
      ovr_mask = 5'b0;
      hif.guess_valid = 1'b0;
      hif.guess_char = 5'd0;
      test_reset;
      test_start;
      test_hit;
      test_dup;
      test_miss_saturate;
      test_win;
      test_restart;
      test_desync_lose;
      test_reset_mid_wait;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 time units, want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
